// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
//   Bit-timing engine for the UART TX/RX datapaths. Three cascaded counters
//   (clock prescaler -> oversample counter -> bit counter) are sequenced by a
//   two-state IDLE/RUN FSM driven by a start/abort handshake. The engine
//   emits registered strobes to the shift-register control.
//
//   Optional feature macro: UART_TIMER_MIDBIT_EN adds the mid_tick output
//   (centre-of-bit strobe for RX sampling).
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        begin a frame (sampled only in IDLE, wins over abort)
//   abort        cancel the running frame (sampled only in RUN)
//   divisor      D: one sample tick every D+1 clk cycles
//   frame_bits   N: bit periods per frame, N=0 makes start a no-op
//   busy         high while a frame is being timed
//   sample_tick  1-cycle strobe once per D+1 cycles in RUN
//   bit_tick     1-cycle strobe on the last sample tick of each bit
//   bit_index    index of the bit currently being timed
//   frame_done   1-cycle strobe coincident with the final bit_tick
//   mid_tick     (UART_TIMER_MIDBIT_EN) strobe on sample tick OS_RATE/2
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16,
  parameter int OS_RATE   = 16,
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [BIT_WIDTH-1:0] frame_bits,
  output logic                 busy,
  output logic                 sample_tick,
  output logic                 bit_tick,
  output logic [BIT_WIDTH-1:0] bit_index,
  output logic                 frame_done
`ifdef UART_TIMER_MIDBIT_EN
  ,
  output logic                 mid_tick
`endif
);

  localparam int OS_W = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]      OS_ONE   = OS_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIT_WIDTH-1:0] BIT_ZERO = {BIT_WIDTH{1'b0}};
  localparam logic [BIT_WIDTH-1:0] BIT_ONE  = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_r,  state_s;
  logic [DIV_WIDTH-1:0]   presc_r,  presc_s;
  logic [OS_W-1:0]        os_cnt_r, os_cnt_s;
  logic [BIT_WIDTH-1:0]   bit_idx_r, bit_idx_s;
  logic [DIV_WIDTH-1:0]   div_r,    div_s;
  logic [BIT_WIDTH-1:0]   nbits_r,  nbits_s;

  logic busy_r;
  logic sample_tick_r;
  logic bit_tick_r;
  logic frame_done_r;

  // Look-ahead strobes: the counter values for the *next* cycle decide what
  // that cycle shows, so every strobe can come straight out of a flop.
  // os_cnt counts sample ticks already completed in the current bit, so the
  // next tick is number os_cnt_s+1 of the bit.
  logic tick_s;
  logic bit_tick_s;
  logic frame_done_s;

  // Next-state and counter update logic.
  always_comb begin
    state_s   = state_r;
    presc_s   = presc_r;
    os_cnt_s  = os_cnt_r;
    bit_idx_s = bit_idx_r;
    div_s     = div_r;
    nbits_s   = nbits_r;

    case (state_r)
      S_IDLE: begin
        presc_s   = DIV_ZERO;
        os_cnt_s  = {OS_W{1'b0}};
        bit_idx_s = BIT_ZERO;
        if (start && (frame_bits != BIT_ZERO)) begin
          state_s = S_RUN;
          div_s   = divisor;
          nbits_s = frame_bits;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_RUN: begin
        if (abort) begin
          // abort beats any tick that would fall due on this edge
          state_s   = S_IDLE;
          presc_s   = DIV_ZERO;
          os_cnt_s  = {OS_W{1'b0}};
          bit_idx_s = BIT_ZERO;
        end else begin
          if (presc_r == div_r) begin
            presc_s = DIV_ZERO;
          end else begin
            presc_s = presc_r + DIV_ONE;
          end

          // The registered strobes describe the cycle now ending.
          if (sample_tick_r) begin
            if (bit_tick_r) begin
              os_cnt_s = {OS_W{1'b0}};
              if (frame_done_r) begin
                state_s   = S_IDLE;
                presc_s   = DIV_ZERO;
                bit_idx_s = BIT_ZERO;
              end else begin
                bit_idx_s = bit_idx_r + BIT_ONE;
              end
            end else begin
              os_cnt_s = os_cnt_r + OS_ONE;
            end
          end else begin
            os_cnt_s = os_cnt_r;
          end
        end
      end

      default: begin
        state_s   = S_IDLE;
        presc_s   = DIV_ZERO;
        os_cnt_s  = {OS_W{1'b0}};
        bit_idx_s = BIT_ZERO;
      end
    endcase
  end

  // Strobe decode for the upcoming cycle.
  always_comb begin
    tick_s       = (state_s == S_RUN) && (presc_s == div_s);
    bit_tick_s   = tick_s && (os_cnt_s == OS_LAST);
    frame_done_s = bit_tick_s && (bit_idx_s == (nbits_s - BIT_ONE));
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      presc_r       <= DIV_ZERO;
      os_cnt_r      <= {OS_W{1'b0}};
      bit_idx_r     <= BIT_ZERO;
      div_r         <= DIV_ZERO;
      nbits_r       <= BIT_ZERO;
      busy_r        <= 1'b0;
      sample_tick_r <= 1'b0;
      bit_tick_r    <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      presc_r       <= presc_s;
      os_cnt_r      <= os_cnt_s;
      bit_idx_r     <= bit_idx_s;
      div_r         <= div_s;
      nbits_r       <= nbits_s;
      busy_r        <= (state_s == S_RUN);
      sample_tick_r <= tick_s;
      bit_tick_r    <= bit_tick_s;
      frame_done_r  <= frame_done_s;
    end
  end

  assign busy        = busy_r;
  assign sample_tick = sample_tick_r;
  assign bit_tick    = bit_tick_r;
  assign bit_index   = bit_idx_r;
  assign frame_done  = frame_done_r;

`ifdef UART_TIMER_MIDBIT_EN
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OS_RATE / 2 - 1);

  logic mid_tick_r;
  logic mid_tick_s;

  // Centre-of-bit strobe: the upcoming tick is number OS_RATE/2 of its bit.
  always_comb begin
    mid_tick_s = tick_s && (os_cnt_s == OS_MID);
  end

  // Mid-bit strobe register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mid_tick_r <= 1'b0;
    end else begin
      mid_tick_r <= mid_tick_s;
    end
  end

  assign mid_tick = mid_tick_r;
`endif

endmodule

// File: tb/tb_uart_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_uart_bit_timer
//   Directed bench for uart_bit_timer with default parameters (OS_RATE=16).
//   Expected bit_tick cycles are queued when a frame is launched and popped
//   as the DUT produces bit_tick strobes. Cycle 1 is the first busy cycle.
// ---------------------------------------------------------------------------
module tb_uart_bit_timer;

  localparam int DW = 16;
  localparam int BW = 4;
  localparam int OS = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] divisor;
  logic [BW-1:0] frame_bits;
  logic          busy;
  logic          sample_tick;
  logic          bit_tick;
  logic [BW-1:0] bit_index;
  logic          frame_done;
`ifdef UART_TIMER_MIDBIT_EN
  logic          mid_tick;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_q[$];

  uart_bit_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .divisor    (divisor),
    .frame_bits (frame_bits),
    .busy       (busy),
    .sample_tick(sample_tick),
    .bit_tick   (bit_tick),
    .bit_index  (bit_index),
    .frame_done (frame_done)
`ifdef UART_TIMER_MIDBIT_EN
    ,
    .mid_tick   (mid_tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Launch one frame from a negedge and follow it until busy drops.
  task automatic run_frame(input int d, input int n, input int abort_at,
                           input bit hold, input bit abort_w_start, input int new_div_at);
    int t_exp;
    int c;
    int busy_len;
    int st_err;
    int ticks;
    int dones;
    int t;
`ifdef UART_TIMER_MIDBIT_EN
    int mt_err;
    int k;
    mt_err = 0;
`endif
    t_exp    = (abort_at > 0) ? abort_at : n * OS * (d + 1);
    c        = 0;
    busy_len = 0;
    st_err   = 0;
    ticks    = 0;
    dones    = 0;
    exp_q.delete();
    for (int b = 0; b < n; b++) begin
      t = OS * (d + 1) * (b + 1);
      if (abort_at == 0 || t <= abort_at) exp_q.push_back(t);
    end

    divisor    = d[DW-1:0];
    frame_bits = n[BW-1:0];
    start      = 1'b1;
    abort      = abort_w_start;
    @(posedge clk);

    while (c < t_exp + 8) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        if (!hold) start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
      end
      abort = (abort_at > 0) && (c == abort_at);
      if (c == new_div_at) divisor = divisor ^ 16'h00ff;
      if (busy !== 1'b1) break;
      busy_len = c;

      if (sample_tick !== ((c % (d + 1)) == 0)) st_err++;
`ifdef UART_TIMER_MIDBIT_EN
      k = c / (d + 1);
      if (mid_tick !== (((c % (d + 1)) == 0) && (((k - 1) % OS) == (OS / 2 - 1)))) mt_err++;
`endif
      if (bit_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("bt_extra", c, 32'd0);
        end else begin
          check("bt_cycle", c, exp_q.pop_front());
          check("bt_index", 32'(bit_index), ticks);
        end
        ticks++;
      end
      if (frame_done === 1'b1) begin
        dones++;
        check("fd_cycle", c, n * OS * (d + 1));
        check("fd_with_bt", 32'(bit_tick), 32'd1);
      end
    end

    check("busy_len", busy_len, t_exp);
    check("st_pattern_errs", st_err, 32'd0);
    check("bt_missing", exp_q.size(), 32'd0);
    check("fd_count", dones, (abort_at > 0) ? 32'd0 : 32'd1);
    check("idx_idle", 32'(bit_index), 32'd0);
`ifdef UART_TIMER_MIDBIT_EN
    check("mid_pattern_errs", mt_err, 32'd0);
`endif
  endtask

  initial begin
    int err;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    divisor    = 16'd0;
    frame_bits = 4'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample", 32'(sample_tick), 32'd0);
    check("rst_bit", 32'(bit_tick), 32'd0);
    check("rst_index", 32'(bit_index), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // D=3 N=10: 640-cycle frame, bit ticks every 64 cycles
    run_frame(3, 10, 0, 1'b0, 1'b0, 0);
    // D=0 N=1: single 16-cycle bit
    run_frame(0, 1, 0, 1'b0, 1'b0, 0);
    // D=1 N=4 aborted at cycle 70, then a full 128-cycle frame
    run_frame(1, 4, 70, 1'b0, 1'b0, 0);
    run_frame(1, 4, 0, 1'b0, 1'b0, 0);
    // start held: back-to-back frames, one idle cycle apart, divisor poked mid-frame
    run_frame(0, 2, 0, 1'b1, 1'b0, 10);
    run_frame(0, 2, 0, 1'b1, 1'b0, 10);
    start = 1'b0;
    @(negedge clk);
    // start and abort together in IDLE: start wins
    run_frame(0, 1, 0, 1'b0, 1'b1, 0);
    // a larger divisor
    run_frame(5, 2, 0, 1'b0, 1'b0, 0);

    // asynchronous reset at cycle 50 of a D=0 N=10 frame
    divisor    = 16'd0;
    frame_bits = 4'd10;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_index", 32'(bit_index), 32'd3);
    check("pre_rst_sample", 32'(sample_tick), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sample", 32'(sample_tick), 32'd0);
    check("arst_index", 32'(bit_index), 32'd0);
    check("arst_bit", 32'(bit_tick), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // start with N=0 is a no-op
    frame_bits = 4'd0;
    start      = 1'b1;
    err        = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0) err++;
    end
    start = 1'b0;
    check("n0_busy_cycles", err, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
